// File: rtl/spi_slave.sv
// SPI slave engine: the responder end of the link driven by the SPI master.
//
// SCK, SS and MOSI are oversampled in the clk_in domain. One frame of
// DATA_WIDTH bits is shifted per SS-low window, and frames continue back to
// back while SS stays low. A single-entry TX holding buffer and a single-entry
// RX buffer face the register/bus front-end. All four CPOL/CPHA modes and
// MSB/LSB-first ordering are supported.
//
// Ports:
//   clk_in, rst_in          system clock, async active-high reset
//   spe_in                  enable; low forces DISABLE
//   cpol_in, cpha_in        SPI mode; lsbfe_in selects LSB-first
//   sck_in, ss_in, mosi_in  asynchronous SPI inputs (ss_in active-low)
//   miso_out, miso_oe_out   slave data out and pad enable
//   tx_data_in, tx_wr_in    TX buffer write; tx_empty_out status
//   rx_data_out, rx_full_out, rx_rd_in   RX buffer and read strobe
//   overrun_out, underrun_out, abort_out 1-cycle event pulses
//   busy_out                high while a transfer window is open
//
// state   | meaning
// DISABLE | spe_in low; shifter idle, buffers retained
// IDLE    | enabled, waiting for SS to fall
// SHIFT   | SS low, frames being shifted
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  spe_in,
    input  logic                  cpol_in,
    input  logic                  cpha_in,
    input  logic                  lsbfe_in,
    input  logic                  sck_in,
    input  logic                  ss_in,
    input  logic                  mosi_in,
    output logic                  miso_out,
    output logic                  miso_oe_out,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  tx_wr_in,
    output logic                  tx_empty_out,
    output logic [DATA_WIDTH-1:0] rx_data_out,
    output logic                  rx_full_out,
    input  logic                  rx_rd_in,
    output logic                  overrun_out,
    output logic                  underrun_out,
    output logic                  abort_out,
    output logic                  busy_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_DISABLE,
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic                   sck_d, ss_d;
    logic                   sck_s, ss_s, mosi_s;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   ss_fall, ss_rise;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_sr, tx_sr, tx_buf, load_data;
    logic                   frame_done, start_load, reload, load_evt;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] d,
                                                      input logic lsb);
        return lsb ? {1'b0, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], 1'b0};
    endfunction

    // Synchronizers plus one extra stage on SCK/SS for edge detection.
    // SS resets high so that leaving reset never looks like a select.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
        end
    end

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign lead_edge   = (sck_d == cpol_in) && (sck_s != cpol_in);
    assign trail_edge  = (sck_d != cpol_in) && (sck_s == cpol_in);
    assign sample_edge = cpha_in ? trail_edge : lead_edge;
    assign shift_edge  = cpha_in ? lead_edge : trail_edge;
    assign ss_fall     = ss_d && !ss_s;
    assign ss_rise     = !ss_d && ss_s;

    assign frame_done = spe_in && (state == ST_SHIFT) && (bit_cnt == CNT_W'(DATA_WIDTH));
    assign start_load = spe_in && (state == ST_IDLE) && ss_fall;
    // A frame ending in the same cycle SS rises must not consume the buffer.
    assign reload     = frame_done && !ss_rise;
    assign load_evt   = start_load || reload;
    assign load_data  = tx_empty_out ? '0 : tx_buf;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_DISABLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_DISABLE: if (spe_in) state_next = ST_IDLE;
            ST_IDLE:    if (ss_fall) state_next = ST_SHIFT;
            ST_SHIFT:   if (ss_rise) state_next = ST_IDLE;
            default:    state_next = ST_DISABLE;
        endcase
        if (!spe_in) state_next = ST_DISABLE;
    end

    assign miso_oe_out = (state == ST_SHIFT);
    assign busy_out    = (state == ST_SHIFT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_cnt      <= '0;
            rx_sr        <= '0;
            tx_sr        <= '0;
            miso_out     <= 1'b0;
            tx_buf       <= '0;
            tx_empty_out <= 1'b1;
            rx_data_out  <= '0;
            rx_full_out  <= 1'b0;
            overrun_out  <= 1'b0;
            underrun_out <= 1'b0;
            abort_out    <= 1'b0;
        end else begin
            overrun_out  <= 1'b0;
            underrun_out <= 1'b0;
            abort_out    <= 1'b0;

            // A load sees the buffer as it was before any same-cycle write;
            // a write into an empty buffer during a load survives for later.
            if (load_evt && !tx_empty_out) begin
                tx_empty_out <= 1'b1;
            end else if (tx_wr_in && tx_empty_out) begin
                tx_buf       <= tx_data_in;
                tx_empty_out <= 1'b0;
            end
            if (load_evt && tx_empty_out) underrun_out <= 1'b1;

            if (frame_done) begin
                if (!rx_full_out || rx_rd_in) begin
                    rx_data_out <= rx_sr;
                    rx_full_out <= 1'b1;
                end else begin
                    overrun_out <= 1'b1;
                end
            end else if (rx_rd_in) begin
                rx_full_out <= 1'b0;
            end

            if (!spe_in) begin
                bit_cnt  <= '0;
                rx_sr    <= '0;
                tx_sr    <= '0;
                miso_out <= 1'b0;
            end else if (start_load) begin
                bit_cnt <= '0;
                rx_sr   <= '0;
                // CPHA=0 has no shift edge before the first sample, so the
                // first bit goes out with the output enable.
                if (cpha_in) begin
                    tx_sr <= load_data;
                end else begin
                    miso_out <= first_bit(load_data, lsbfe_in);
                    tx_sr    <= advance(load_data, lsbfe_in);
                end
            end else if (state == ST_SHIFT) begin
                if (ss_rise) begin
                    if ((bit_cnt != '0) && !frame_done) abort_out <= 1'b1;
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                end else if (frame_done) begin
                    // Reloaded unshifted: the next shift edge presents bit one
                    // of the new frame in both CPHA settings.
                    bit_cnt <= '0;
                    tx_sr   <= load_data;
                end else begin
                    if (sample_edge) begin
                        rx_sr   <= lsbfe_in ? {mosi_s, rx_sr[DATA_WIDTH-1:1]}
                                            : {rx_sr[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                    if (shift_edge) begin
                        miso_out <= first_bit(tx_sr, lsbfe_in);
                        tx_sr    <= advance(tx_sr, lsbfe_in);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

    localparam int W = 8;
    localparam int H = 8;   // SCK half period in clk_in cycles

    localparam int EV_RX  = 0;
    localparam int EV_OVR = 1;
    localparam int EV_UND = 2;
    localparam int EV_ABT = 3;

    logic         clk_in = 1'b0;
    logic         rst_in = 1'b1;
    logic         spe_in = 1'b0;
    logic         cpol_in = 1'b0;
    logic         cpha_in = 1'b0;
    logic         lsbfe_in = 1'b0;
    logic         sck_in = 1'b0;
    logic         ss_in = 1'b1;
    logic         mosi_in = 1'b0;
    logic         miso_out, miso_oe_out;
    logic [W-1:0] tx_data_in = '0;
    logic         tx_wr_in = 1'b0;
    logic         tx_empty_out;
    logic [W-1:0] rx_data_out;
    logic         rx_full_out;
    logic         rx_rd_in = 1'b0;
    logic         overrun_out, underrun_out, abort_out, busy_out;

    always #5 clk_in = ~clk_in;

    spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .spe_in      (spe_in),
        .cpol_in     (cpol_in),
        .cpha_in     (cpha_in),
        .lsbfe_in    (lsbfe_in),
        .sck_in      (sck_in),
        .ss_in       (ss_in),
        .mosi_in     (mosi_in),
        .miso_out    (miso_out),
        .miso_oe_out (miso_oe_out),
        .tx_data_in  (tx_data_in),
        .tx_wr_in    (tx_wr_in),
        .tx_empty_out(tx_empty_out),
        .rx_data_out (rx_data_out),
        .rx_full_out (rx_full_out),
        .rx_rd_in    (rx_rd_in),
        .overrun_out (overrun_out),
        .underrun_out(underrun_out),
        .abort_out   (abort_out),
        .busy_out    (busy_out)
    );

    typedef struct {
        int kind;
        int data;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input int data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event: got unexpected kind %0d data 0x%0h, expected none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data != data) begin
                failures++;
                $display("FAIL event: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                         kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every DUT event is compared against the front of the queue.
    initial begin
        logic         prev_full;
        logic [W-1:0] prev_data;
        prev_full = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                prev_full = 1'b0;
                prev_data = '0;
            end else begin
                if ((rx_full_out && !prev_full) || (rx_data_out != prev_data))
                    observe(EV_RX, int'(rx_data_out));
                if (overrun_out)  observe(EV_OVR, 0);
                if (underrun_out) observe(EV_UND, 0);
                if (abort_out)    observe(EV_ABT, 0);
                prev_full = rx_full_out;
                prev_data = rx_data_out;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic pulse_wr(input logic [W-1:0] d);
        tx_data_in = d;
        tx_wr_in   = 1'b1;
        @(negedge clk_in);
        tx_wr_in   = 1'b0;
    endtask

    task automatic pulse_rd();
        rx_rd_in = 1'b1;
        @(negedge clk_in);
        rx_rd_in = 1'b0;
    endtask

    task automatic wait_tx_empty(input string name);
        int n = 0;
        while (!tx_empty_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk(name, tx_empty_out, 1);
    endtask

    // Select the slave; optionally queue the next TX byte once the buffer
    // has been consumed so the end-of-frame reload does not underrun.
    task automatic ss_start(input logic [W-1:0] next_tx, input bit refill);
        ss_in = 1'b0;
        repeat (5) @(negedge clk_in);
        if (refill) begin
            wait_tx_empty("tx_empty_after_load");
            pulse_wr(next_tx);
        end
        repeat (H) @(negedge clk_in);
    endtask

    task automatic ss_stop();
        repeat (H) @(negedge clk_in);
        ss_in = 1'b1;
        repeat (H) @(negedge clk_in);
    endtask

    // Master side: drives nbits of m, records MISO at each sample edge in
    // wire order (first bit received ends up in the MSB of seq).
    task automatic xfer(input logic [W-1:0] m, input int nbits,
                        output logic [W-1:0] seq, output bit oe_ok);
        seq   = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = lsbfe_in ? m[i] : m[W-1-i];
            if (!cpha_in) begin
                mosi_in = b;
                repeat (H) @(negedge clk_in);
                seq   = {seq[W-2:0], miso_out};
                oe_ok = oe_ok & miso_oe_out;
                sck_in = ~cpol_in;
                repeat (H) @(negedge clk_in);
                sck_in = cpol_in;
            end else begin
                sck_in  = ~cpol_in;
                mosi_in = b;
                repeat (H) @(negedge clk_in);
                seq   = {seq[W-2:0], miso_out};
                oe_ok = oe_ok & miso_oe_out;
                sck_in = cpol_in;
                repeat (H) @(negedge clk_in);
            end
        end
    endtask

    logic [W-1:0] seq;
    bit           oe_ok;

    initial begin
        repeat (4) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Reset values
        chk("rst_miso", miso_out, 0);
        chk("rst_miso_oe", miso_oe_out, 0);
        chk("rst_tx_empty", tx_empty_out, 1);
        chk("rst_rx_data", rx_data_out, 0);
        chk("rst_rx_full", rx_full_out, 0);
        chk("rst_busy", busy_out, 0);

        // Mode 0, MSB first: slave 0xA5, master 0x3C
        spe_in = 1'b1;
        repeat (3) @(negedge clk_in);
        pulse_wr(8'hA5);
        chk("m0_tx_full", tx_empty_out, 0);
        push(EV_RX, 8'h3C);
        ss_start(8'h00, 1);
        xfer(8'h3C, 8, seq, oe_ok);
        chk("m0_miso_bits", seq, 8'hA5);
        chk("m0_miso_oe", oe_ok, 1);
        ss_stop();
        chk("m0_rx_data", rx_data_out, 8'h3C);
        chk("m0_rx_full", rx_full_out, 1);
        chk("m0_tx_empty", tx_empty_out, 1);
        chk("m0_busy_idle", busy_out, 0);
        pulse_rd();
        chk("m0_rx_cleared", rx_full_out, 0);

        // Mode 3, LSB first: slave 0x81, master 0x96
        cpol_in = 1'b1; cpha_in = 1'b1; lsbfe_in = 1'b1; sck_in = 1'b1;
        repeat (5) @(negedge clk_in);
        pulse_wr(8'h81);
        push(EV_RX, 8'h96);
        ss_start(8'h00, 1);
        xfer(8'h96, 8, seq, oe_ok);
        chk("m3_miso_bits", seq, 8'h81);
        ss_stop();
        chk("m3_rx_data", rx_data_out, 8'h96);
        pulse_rd();

        // Back-to-back frames in mode 0 with SS held low
        cpol_in = 1'b0; cpha_in = 1'b0; lsbfe_in = 1'b0; sck_in = 1'b0;
        repeat (5) @(negedge clk_in);
        pulse_wr(8'h11);
        push(EV_RX, 8'h55);
        ss_start(8'h22, 1);
        xfer(8'h55, 8, seq, oe_ok);
        chk("b2b_miso_f1", seq, 8'h11);
        repeat (4) @(negedge clk_in);
        pulse_rd();
        chk("b2b_rd_clear", rx_full_out, 0);
        wait_tx_empty("b2b_tx_reloaded");
        pulse_wr(8'h33);
        push(EV_RX, 8'hAA);
        xfer(8'hAA, 8, seq, oe_ok);
        chk("b2b_miso_f2", seq, 8'h22);
        ss_stop();
        chk("b2b_rx_data", rx_data_out, 8'hAA);
        pulse_rd();

        // Underrun at SS fall, overrun at frame end
        pulse_wr(8'h00);
        push(EV_RX, 8'h01);
        ss_start(8'h00, 1);
        xfer(8'h01, 8, seq, oe_ok);
        ss_stop();
        chk("uo_rx_full_pre", rx_full_out, 1);
        push(EV_UND, 0);
        ss_start(8'h00, 1);
        push(EV_OVR, 0);
        xfer(8'hF0, 8, seq, oe_ok);
        chk("uo_miso_zero", seq, 8'h00);
        ss_stop();
        chk("uo_rx_data_kept", rx_data_out, 8'h01);
        chk("uo_rx_full_kept", rx_full_out, 1);
        pulse_rd();

        // Abort after 5 sample edges, then a clean frame
        pulse_wr(8'h5A);
        ss_start(8'h00, 0);
        xfer(8'h33, 5, seq, oe_ok);
        push(EV_ABT, 0);
        repeat (2) @(negedge clk_in);
        ss_in = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("abort_miso_oe", miso_oe_out, 0);
        chk("abort_rx_full", rx_full_out, 0);
        chk("abort_busy", busy_out, 0);
        pulse_wr(8'hC3);
        push(EV_RX, 8'h7E);
        ss_start(8'h00, 1);
        xfer(8'h7E, 8, seq, oe_ok);
        chk("post_abort_miso", seq, 8'hC3);
        ss_stop();
        chk("post_abort_rx", rx_data_out, 8'h7E);

        // Reset mid-frame (0x7E still unread)
        pulse_wr(8'h3B);
        ss_start(8'h44, 1);
        xfer(8'h0F, 3, seq, oe_ok);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_miso", miso_out, 0);
        chk("mid_rst_miso_oe", miso_oe_out, 0);
        chk("mid_rst_tx_empty", tx_empty_out, 1);
        chk("mid_rst_rx_data", rx_data_out, 0);
        chk("mid_rst_rx_full", rx_full_out, 0);
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_pulses", {overrun_out, underrun_out, abort_out}, 0);
        ss_in = 1'b1; sck_in = cpol_in; mosi_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (3) @(negedge clk_in);

        // Disable mid-frame: no abort, RX buffer retained
        pulse_wr(8'h12);
        push(EV_RX, 8'h42);
        ss_start(8'h00, 1);
        xfer(8'h42, 8, seq, oe_ok);
        chk("dis_pre_miso", seq, 8'h12);
        ss_stop();
        pulse_wr(8'h99);
        ss_start(8'h00, 0);
        xfer(8'hFF, 4, seq, oe_ok);
        spe_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("dis_busy", busy_out, 0);
        chk("dis_miso_oe", miso_oe_out, 0);
        chk("dis_miso", miso_out, 0);
        chk("dis_rx_full", rx_full_out, 1);
        chk("dis_rx_data", rx_data_out, 8'h42);
        ss_in = 1'b1;
        repeat (10) @(negedge clk_in);
        spe_in = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("dis_reenable_idle", busy_out, 0);

        repeat (10) @(negedge clk_in);
        chk("events_outstanding", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
